// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder
//   HD44780-compatible responder for the 8-bit parallel LCD bus. Samples E
//   strobes, decodes instructions and data writes, keeps the visible 2x16
//   DDRAM image and answers busy-flag / data reads.
//
//   Ports:
//     mclk, rst          system clock, synchronous active-high reset
//     E, RS, RW, DB_in   LCD bus from the controller (asynchronous to mclk)
//     DB_out, DB_oe      read data and its drive enable
//     lineA, lineB       row 0 / row 1 characters, char i at [8*i+7:8*i]
//     disp_on, two_line  D bit of display control, N bit of function set
//     busy               internal busy flag
//     wr_pulse           one-cycle pulse per accepted write
//     proto_err          sticky protocol-error flag
//
//   Optional feature: define LCD_RESP_BUSY_MODEL_EN to model busy timing
//   (CLEAR_CYCLES / EXEC_CYCLES). Without it every strobe is accepted
//   back-to-back and busy is tied low.
module lcd_bus_responder #(
  parameter int CLEAR_CYCLES = 64,
  parameter int EXEC_CYCLES  = 8
) (
  input  logic         mclk,
  input  logic         rst,
  input  logic         E,
  input  logic         RS,
  input  logic         RW,
  input  logic [7:0]   DB_in,
  output logic [7:0]   DB_out,
  output logic         DB_oe,
  output logic [127:0] lineA,
  output logic [127:0] lineB,
  output logic         disp_on,
  output logic         two_line,
  output logic         busy,
  output logic         wr_pulse,
  output logic         proto_err
);

`ifdef LCD_RESP_BUSY_MODEL_EN
  localparam bit BUSY_MODEL = 1'b1;
`else
  localparam bit BUSY_MODEL = 1'b0;
`endif

  localparam int MAXC = (CLEAR_CYCLES > EXEC_CYCLES) ? CLEAR_CYCLES : EXEC_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, EXEC} state_t;
  state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;

  logic       e_s1, e_s2, e_d;
  logic       rs_s1, rs_s2, rs_d;
  logic       rw_s1, rw_s2, rw_d;
  logic [7:0] db_s1, db_s2, db_d;

  logic [6:0] addr;
  logic       inc_mode;
  logic       cg_mode;

  logic strobe, in_exec, wr_strobe, data_rd;
  logic accept_wr, accept_rd, violation, is_nop, is_long;

  // Address step with the two-line DDRAM wrap (0x27<->0x40, 0x67<->0x00).
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
    if (up) begin
      if (a == 7'h27) return 7'h40;
      if (a == 7'h67) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h00) return 7'h67;
    if (a == 7'h40) return 7'h27;
    return a - 7'd1;
  endfunction

  function automatic logic addr_valid(input logic [6:0] a);
    return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
  endfunction

  // Only the first 16 cells of each row are stored; the rest read as blanks.
  function automatic logic [7:0] char_at(input logic [6:0] a,
                                         input logic [127:0] la,
                                         input logic [127:0] lb);
    if (a[6:4] == 3'b000) return la[{a[3:0], 3'b000} +: 8];
    if (a[6:4] == 3'b100) return lb[{a[3:0], 3'b000} +: 8];
    return 8'h20;
  endfunction

  // Two-flop synchroniser on every bus signal, plus a third stage so that
  // RS/RW/DB line up with the delayed E used for falling-edge detection.
  always_ff @(posedge mclk) begin
    if (rst) begin
      {e_s1, e_s2, e_d}    <= 3'b000;
      {rs_s1, rs_s2, rs_d} <= 3'b000;
      {rw_s1, rw_s2, rw_d} <= 3'b000;
      db_s1 <= 8'h00;
      db_s2 <= 8'h00;
      db_d  <= 8'h00;
    end else begin
      e_s1  <= E;     e_s2  <= e_s1;  e_d  <= e_s2;
      rs_s1 <= RS;    rs_s2 <= rs_s1; rs_d <= rs_s2;
      rw_s1 <= RW;    rw_s2 <= rw_s1; rw_d <= rw_s2;
      db_s1 <= DB_in; db_s2 <= db_s1; db_d <= db_s2;
    end
  end

  assign strobe    = e_d & ~e_s2;
  assign in_exec   = (state == EXEC);
  assign wr_strobe = strobe & ~rw_d;
  assign data_rd   = strobe & rw_d & rs_d;
  // Status reads are always allowed; writes and data reads collide with busy.
  assign violation = BUSY_MODEL & in_exec & (wr_strobe | data_rd);
  assign accept_wr = wr_strobe & ~in_exec;
  assign accept_rd = data_rd & ~in_exec;
  assign is_nop    = ~rs_d & (db_d == 8'h00);
  assign is_long   = ~rs_d & (db_d[7:2] == 6'd0) & (db_d[1:0] != 2'd0);
  assign busy      = BUSY_MODEL & in_exec;
  assign DB_oe     = e_s2 & rw_s2;

  always_ff @(posedge mclk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Counter is loaded with N-1 so busy stays high for exactly N cycles.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (BUSY_MODEL && accept_wr && !is_nop) begin
          state_next = EXEC;
          cnt_next   = is_long ? CW'(CLEAR_CYCLES - 1) : CW'(EXEC_CYCLES - 1);
        end
      end
      EXEC: begin
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - CW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      lineA     <= {16{8'h20}};
      lineB     <= {16{8'h20}};
      addr      <= 7'h00;
      inc_mode  <= 1'b1;
      cg_mode   <= 1'b0;
      disp_on   <= 1'b0;
      two_line  <= 1'b0;
      DB_out    <= 8'h00;
      wr_pulse  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      wr_pulse <= 1'b0;
      if (e_s2 && rw_s2) DB_out <= rs_s2 ? char_at(addr, lineA, lineB) : {busy, addr};
      if (violation) proto_err <= 1'b1;
      if (accept_rd) addr <= step_addr(addr, inc_mode);
      if (accept_wr) begin
        wr_pulse <= 1'b1;
        if (rs_d) begin
          // In CG mode the character is dropped but the cursor still moves.
          if (!cg_mode) begin
            if (addr[6:4] == 3'b000)      lineA[{addr[3:0], 3'b000} +: 8] <= db_d;
            else if (addr[6:4] == 3'b100) lineB[{addr[3:0], 3'b000} +: 8] <= db_d;
          end
          addr <= step_addr(addr, inc_mode);
        end else begin
          casez (db_d)
            8'b1???????: begin
              cg_mode <= 1'b0;
              if (addr_valid(db_d[6:0])) addr <= db_d[6:0];
              else begin
                addr      <= 7'h00;
                proto_err <= 1'b1;
              end
            end
            8'b01??????: cg_mode  <= 1'b1;
            8'b001?????: two_line <= db_d[3];
            8'b0001????: if (!db_d[3]) addr <= step_addr(addr, db_d[2]);
            8'b00001???: disp_on  <= db_d[2];
            8'b000001??: inc_mode <= db_d[1];
            8'b0000001?: addr     <= 7'h00;
            8'b00000001: begin
              lineA    <= {16{8'h20}};
              lineB    <= {16{8'h20}};
              addr     <= 7'h00;
              inc_mode <= 1'b1;
            end
            default: proto_err <= 1'b1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb_lcd_bus_responder
//   Self-checking bench for lcd_bus_responder: a table of directed bus
//   writes, hand-written busy / reset sequences, and a randomized run
//   against a DDRAM model kept as a flat 80-cell array.
//   Honours LCD_RESP_BUSY_MODEL_EN the same way the design does.
module tb_lcd_bus_responder;

`ifdef LCD_RESP_BUSY_MODEL_EN
  localparam bit BUSY_MODEL = 1'b1;
`else
  localparam bit BUSY_MODEL = 1'b0;
`endif

  logic         mclk = 1'b0;
  logic         rst, E, RS, RW;
  logic [7:0]   DB_in, DB_out;
  logic         DB_oe, disp_on, two_line, busy, wr_pulse, proto_err;
  logic [127:0] lineA, lineB;

  int checks = 0;
  int passes = 0;
  int wrSeen = 0;

  lcd_bus_responder dut (
    .mclk(mclk), .rst(rst), .E(E), .RS(RS), .RW(RW), .DB_in(DB_in),
    .DB_out(DB_out), .DB_oe(DB_oe), .lineA(lineA), .lineB(lineB),
    .disp_on(disp_on), .two_line(two_line), .busy(busy),
    .wr_pulse(wr_pulse), .proto_err(proto_err)
  );

  always #5 mclk = ~mclk;

  always @(negedge mclk) if (wr_pulse === 1'b1) wrSeen++;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic [6:0] expAddr;
    logic       expTwoLine;
    logic       expDispOn;
    logic       expErr;
  } vec_t;
  vec_t vecs [28];

  // Reference model: DDRAM as 80 linear cells (row 0 = 0..39, row 1 = 40..79).
  logic [7:0] mMem [80];
  int mPos;
  bit mInc, mCg, mTwo, mDisp, mErr;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [6:0] addrOfPos(input int p);
    return (p < 40) ? 7'(p) : 7'(p + 24);
  endfunction

  function automatic int posOfAddr(input logic [6:0] a);
    return (a < 7'd64) ? int'(a) : int'(a) - 24;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 80; i++) mMem[i] = 8'h20;
    mPos = 0; mInc = 1; mCg = 0; mTwo = 0; mDisp = 0; mErr = 0;
  endtask

  task automatic modelMove(input bit up);
    mPos = up ? (mPos + 1) % 80 : (mPos + 79) % 80;
  endtask

  function automatic logic [7:0] modelChar();
    if (mPos < 16 || (mPos >= 40 && mPos < 56)) return mMem[mPos];
    return 8'h20;
  endfunction

  task automatic modelWrite(input logic rs, input logic [7:0] d);
    int a;
    if (rs) begin
      if (!mCg) mMem[mPos] = d;
      modelMove(mInc);
    end else if (d[7]) begin
      mCg = 0;
      a = int'(d[6:0]);
      if (a <= 39 || (a >= 64 && a <= 103)) mPos = posOfAddr(d[6:0]);
      else begin mPos = 0; mErr = 1; end
    end else if (d[6]) mCg = 1;
    else if (d[5]) mTwo = d[3];
    else if (d[4]) begin if (!d[3]) modelMove(d[2]); end
    else if (d[3]) mDisp = d[2];
    else if (d[2]) mInc = d[1];
    else if (d[1]) mPos = 0;
    else if (d[0]) begin
      for (int i = 0; i < 80; i++) mMem[i] = 8'h20;
      mPos = 0; mInc = 1;
    end else mErr = 1;
  endtask

  // One write strobe; reports where (1..6 cycles after the E fall) wr_pulse shows.
  task automatic applyStimulus(input logic rs, input logic [7:0] d, output int pulsePos, output int pulseCnt);
    @(negedge mclk);
    RS = rs; RW = 1'b0; DB_in = d; E = 1'b1;
    repeat (4) @(negedge mclk);
    E = 1'b0;
    pulsePos = -1;
    pulseCnt = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge mclk);
      if (wr_pulse === 1'b1) begin
        pulseCnt++;
        if (pulsePos < 0) pulsePos = i;
      end
    end
  endtask

  task automatic readBus(input logic rs, output logic [7:0] val, output logic oeHigh, output logic oeAfter);
    @(negedge mclk);
    RS = rs; RW = 1'b1; DB_in = 8'h00; E = 1'b1;
    repeat (4) @(negedge mclk);
    val = DB_out;
    oeHigh = DB_oe;
    E = 1'b0;
    repeat (6) @(negedge mclk);
    oeAfter = DB_oe;
    RW = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge mclk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      $display("[TB] FAIL %s: busy still %b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic doWrite(input logic rs, input logic [7:0] d);
    int pp, pc;
    applyStimulus(rs, d, pp, pc);
    checkOutput($sformatf("rnd wr_pulse %h", d), 128'(pc * 16 + pp), 128'(16 + 3));
    modelWrite(rs, d);
    waitIdle("rnd idle");
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " busy"}, 128'(busy), 128'(0));
    checkOutput({tag, " DB_out"}, 128'(DB_out), 128'(0));
    checkOutput({tag, " DB_oe"}, 128'(DB_oe), 128'(0));
    checkOutput({tag, " wr_pulse"}, 128'(wr_pulse), 128'(0));
    checkOutput({tag, " proto_err"}, 128'(proto_err), 128'(0));
    checkOutput({tag, " two_line"}, 128'(two_line), 128'(0));
    checkOutput({tag, " disp_on"}, 128'(disp_on), 128'(0));
    checkOutput({tag, " lineA"}, lineA, {16{8'h20}});
    checkOutput({tag, " lineB"}, lineB, {16{8'h20}});
  endtask

  logic [127:0] expA, expB;
  logic [7:0]   rdVal;
  logic         oeH, oeA;
  int           pPos, pCnt, wrBase, firstBusy, busyCnt;

  initial begin
    rst = 1'b1; E = 1'b0; RS = 1'b0; RW = 1'b0; DB_in = 8'h00;

    vecs[0]  = '{1'b0, 8'h38, 7'h00, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h0C, 7'h00, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'h06, 7'h00, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h01, 7'h00, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h80, 7'h00, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 8'h4D, 7'h01, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 8'h6F, 7'h02, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 8'h6E, 7'h03, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'hC5, 7'h45, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 8'h41, 7'h46, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'hA7, 7'h27, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 8'h58, 7'h40, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 8'h59, 7'h41, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 8'h10, 7'h40, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 8'h10, 7'h27, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 8'h14, 7'h40, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 8'h80, 7'h00, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 8'h10, 7'h67, 1'b1, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 8'h14, 7'h00, 1'b1, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 8'hE7, 7'h67, 1'b1, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 8'h14, 7'h00, 1'b1, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 8'h00, 7'h00, 1'b1, 1'b1, 1'b1};
    vecs[22] = '{1'b0, 8'h85, 7'h05, 1'b1, 1'b1, 1'b1};
    vecs[23] = '{1'b0, 8'hA8, 7'h00, 1'b1, 1'b1, 1'b1};
    vecs[24] = '{1'b0, 8'h08, 7'h00, 1'b1, 1'b0, 1'b1};
    vecs[25] = '{1'b0, 8'h0F, 7'h00, 1'b1, 1'b1, 1'b1};
    vecs[26] = '{1'b0, 8'h85, 7'h05, 1'b1, 1'b1, 1'b1};
    vecs[27] = '{1'b0, 8'h03, 7'h00, 1'b1, 1'b1, 1'b1};

    repeat (3) @(negedge mclk);
    checkReset("reset");
    rst = 1'b0;
    $display("[TB] directed table");

    wrBase = wrSeen;
    for (int i = 0; i < 28; i++) begin
      applyStimulus(vecs[i].rs, vecs[i].data, pPos, pCnt);
      checkOutput($sformatf("vec%0d wr_pulse pos", i), 128'(pPos), 128'(3));
      checkOutput($sformatf("vec%0d wr_pulse cnt", i), 128'(pCnt), 128'(1));
      waitIdle($sformatf("vec%0d idle", i));
      readBus(1'b0, rdVal, oeH, oeA);
      checkOutput($sformatf("vec%0d status", i), 128'(rdVal), 128'({1'b0, vecs[i].expAddr}));
      checkOutput($sformatf("vec%0d DB_oe", i), 128'({oeH, oeA}), 128'(2'b10));
      checkOutput($sformatf("vec%0d flags", i), 128'({two_line, disp_on, proto_err}),
                  128'({vecs[i].expTwoLine, vecs[i].expDispOn, vecs[i].expErr}));
    end
    @(negedge mclk);
    checkOutput("table wr_pulse total", 128'(wrSeen - wrBase), 128'(28));

    expA = {16{8'h20}};
    expB = {16{8'h20}};
    expA[23:0]  = 24'h6E6F4D;
    expB[7:0]   = 8'h59;
    expB[47:40] = 8'h41;
    checkOutput("table lineA", lineA, expA);
    checkOutput("table lineB", lineB, expB);

    $display("[TB] clear busy duration");
    @(negedge mclk);
    RS = 1'b0; RW = 1'b0; DB_in = 8'h01; E = 1'b1;
    repeat (4) @(negedge mclk);
    E = 1'b0;
    firstBusy = -1;
    busyCnt = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge mclk);
      if (busy === 1'b1) begin
        busyCnt++;
        if (firstBusy < 0) firstBusy = i;
      end
    end
    checkOutput("clear busy start", 128'(firstBusy), BUSY_MODEL ? 128'(3) : 128'(-1));
    checkOutput("clear busy length", 128'(busyCnt), BUSY_MODEL ? 128'(64) : 128'(0));
    checkOutput("clear lineA", lineA, {16{8'h20}});
    checkOutput("clear lineB", lineB, {16{8'h20}});

    @(negedge mclk);
    rst = 1'b1;
    @(negedge mclk);
    checkReset("rst2");
    rst = 1'b0;

    $display("[TB] strobes during busy");
    applyStimulus(1'b0, 8'h01, pPos, pCnt);
    repeat (4) @(negedge mclk);
    readBus(1'b0, rdVal, oeH, oeA);
    checkOutput("busy status bit7", 128'(rdVal[7]), 128'(BUSY_MODEL));
    checkOutput("status read no err", 128'(proto_err), 128'(0));
    applyStimulus(1'b0, 8'hC0, pPos, pCnt);
    checkOutput("busy write pulse", 128'(pCnt), BUSY_MODEL ? 128'(0) : 128'(1));
    checkOutput("busy write err", 128'(proto_err), 128'(BUSY_MODEL));
    waitIdle("busy idle");
    readBus(1'b0, rdVal, oeH, oeA);
    checkOutput("busy write ignored", 128'(rdVal), BUSY_MODEL ? 128'(8'h00) : 128'(8'h40));

    $display("[TB] reset during execution");
    applyStimulus(1'b0, 8'h38, pPos, pCnt); waitIdle("d0");
    applyStimulus(1'b0, 8'h0C, pPos, pCnt); waitIdle("d1");
    applyStimulus(1'b0, 8'h00, pPos, pCnt); waitIdle("d2");
    applyStimulus(1'b0, 8'h85, pPos, pCnt); waitIdle("d3");
    readBus(1'b0, rdVal, oeH, oeA);
    checkOutput("pre-reset status", 128'(rdVal), 128'(8'h05));
    applyStimulus(1'b1, 8'h5A, pPos, pCnt);
    checkOutput("pre-reset busy", 128'(busy), 128'(BUSY_MODEL));
    checkOutput("pre-reset char", 128'(lineA[47:40]), 128'(8'h5A));
    rst = 1'b1;
    @(negedge mclk);
    checkReset("rst mid-exec");
    rst = 1'b0;
    applyStimulus(1'b0, 8'h83, pPos, pCnt);
    checkOutput("post-reset accept", 128'(pPos), 128'(3));
    waitIdle("post-reset idle");
    readBus(1'b0, rdVal, oeH, oeA);
    checkOutput("post-reset status", 128'(rdVal), 128'(8'h03));

    $display("[TB] randomized run");
    @(negedge mclk);
    rst = 1'b1;
    @(negedge mclk);
    rst = 1'b0;
    modelReset();
    for (int k = 0; k < 150; k++) begin
      int r;
      logic [7:0] d;
      r = $urandom_range(0, 15);
      d = 8'($urandom);
      if (r <= 4) doWrite(1'b1, 8'($urandom_range(32, 126)));
      else if (r <= 6) begin
        case ($urandom_range(0, 3))
          0: d = 8'h80 | 8'($urandom_range(0, 15));
          1: d = 8'h80 | 8'($urandom_range(64, 79));
          2: d = 8'h80 | 8'($urandom_range(0, 103));
          default: d = 8'h80 | 8'($urandom_range(0, 127));
        endcase
        doWrite(1'b0, d);
      end
      else if (r == 7) doWrite(1'b0, 8'h04 | (d & 8'h03));
      else if (r == 8) doWrite(1'b0, 8'h10 | (d & 8'h0F));
      else if (r == 9) doWrite(1'b0, 8'h08 | (d & 8'h07));
      else if (r == 10) doWrite(1'b0, 8'h20 | (d & 8'h1F));
      else if (r == 11 && d[1:0] == 2'b00) doWrite(1'b0, 8'h40 | (d & 8'h3F));
      else if (r <= 12) begin
        readBus(1'b0, rdVal, oeH, oeA);
        checkOutput("rnd status", 128'(rdVal), 128'({1'b0, addrOfPos(mPos)}));
      end
      else if (r <= 14) begin
        readBus(1'b1, rdVal, oeH, oeA);
        checkOutput("rnd data read", 128'(rdVal), 128'(modelChar()));
        modelMove(mInc);
      end
      else doWrite(1'b0, 8'($urandom_range(1, 3)));
    end

    for (int i = 0; i < 16; i++) begin
      expA[8*i +: 8] = mMem[i];
      expB[8*i +: 8] = mMem[40 + i];
    end
    checkOutput("rnd lineA", lineA, expA);
    checkOutput("rnd lineB", lineB, expB);
    checkOutput("rnd flags", 128'({two_line, disp_on, proto_err}), 128'({mTwo, mDisp, mErr}));
    readBus(1'b0, rdVal, oeH, oeA);
    checkOutput("rnd final status", 128'(rdVal), 128'({1'b0, addrOfPos(mPos)}));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lcd_bus_responder.md
Name: lcd_bus_responder

Overview:
- HD44780-compatible responder for the 8-bit parallel LCD bus (DB, RS, E, RW) driven by the team's LCD controller.
- Samples E strobes and decodes instructions and data writes.
- Maintains a 2x16 visible DDRAM image, presented as lineA/lineB in the same 128-bit packing the controller consumes.
- Used as an on-chip loopback checker and as the bus model in controller testbenches. Also answers busy-flag and data reads.

Parameters:
- CLEAR_CYCLES, 64: busy duration in mclk cycles after clear display (0x01) or return home (0x02/0x03).
- EXEC_CYCLES, 8: busy duration in mclk cycles after any other instruction or data write.

Ports:
- mclk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- E  in  1  enable strobe (asynchronous to mclk)
- RS  in  1  0 = instruction, 1 = data
- RW  in  1  0 = write, 1 = read
- DB_in  in  8  bus data from controller
- DB_out  out  8  read data
- DB_oe  out  1  drive-enable for DB_out
- lineA  out  128  row 0 characters; char i at [8*i+7:8*i]
- lineB  out  128  row 1 characters; same packing
- disp_on  out  1  display on/off bit (D) from instruction 0x08-0x0F
- two_line  out  1  N bit from function set
- busy  out  1  internal busy flag
- wr_pulse  out  1  one-cycle pulse per accepted write
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset: lineA/lineB all 8'h20; addr=0; increment mode; disp_on=0; two_line=0; busy=0; DB_out=0; DB_oe=0; wr_pulse=0; proto_err=0; FSM=IDLE.
- Reset overrides everything, including mid-busy operation; the busy counter clears.
- Synchroniser: E, RS, RW and DB_in all pass through a 2-flop synchroniser of equal depth.
- Strobe detection: a falling edge is detected when the delayed copy of E is 1 and the current synced E is 0. RS, RW and DB are taken from the same synced stage as the delayed E.
- Write latency: line/state update and wr_pulse occur 3 mclk cycles after the E fall at the pins. This is fixed.
- FSM states:
  - IDLE: accepts a strobe.
  - EXEC: counts down the busy counter. busy=1 while in EXEC. Returns to IDLE when the counter reaches 0.
- Strobe while in EXEC: ignored (no state change, no wr_pulse); proto_err set.
- Instruction decode (RS=0, RW=0), by highest set bit:
  - 1xxxxxxx: set DDRAM address.
  - 01xxxxxx: CGRAM address; enter CG mode. Subsequent data writes are discarded but still advance the address.
  - 001xxxxx: two_line=DB[3].
  - 0001xxxx: if DB[3]=0, move cursor (DB[2]=1 right, else left); display shift ignored.
  - 00001xxx: disp_on=DB[2].
  - 000001xx: increment if DB[1]=1, else decrement.
  - 0000001x: addr=0.
  - 00000001: fill both lines with 8'h20; addr=0; increment mode.
  - 0x00: no-op; no busy; proto_err set.
- Set DDRAM address leaves CG mode. Valid addresses are 0x00-0x27 and 0x40-0x67; any other value loads 0x00 and sets proto_err.
- Data write (RS=1, RW=0):
  - addr 0x00-0x0F writes lineA char addr.
  - addr 0x40-0x4F writes lineB char addr-0x40.
  - Other valid addresses (off-screen) are not stored.
  - The address then advances per entry mode.
- Address wrap:
  - Increment: 0x27 -> 0x40; 0x67 -> 0x00.
  - Decrement: 0x00 -> 0x67; 0x40 -> 0x27.
- Reads (RW=1):
  - DB_oe=1 while synced E=1 and RW=1; DB_oe deasserts on the synced E fall.
  - RS=0 read: DB_out={busy, addr[6:0]}. Permitted during EXEC.
  - RS=1 read: DB_out = char at addr (8'h20 for off-screen addresses); the address advances on the E fall. Forbidden during EXEC (proto_err set, no advance).
- Simultaneous rst and strobe: rst wins.

Optional Feature:
- Macro: LCD_RESP_BUSY_MODEL_EN.
- Defined: busy timing as described above.
- Undefined:
  - FSM never enters EXEC; busy is tied 0.
  - Every strobe is accepted back-to-back.
  - The busy-violation proto_err source is removed.

Test Plan:
- Reset, then controller-style init 0x38, 0x0C, 0x06, 0x01 -> two_line=1, disp_on=1, lineA=lineB=all 8'h20, proto_err=0. After the clear, busy stays high for exactly 64 cycles.
- 0x80 then data 0x4D, 0x6F, 0x6E -> lineA[23:0]=24'h6E6F4D; wr_pulse fires 4 times (1 instruction + 3 data); addr=0x03.
- 0xC5 then data 0x41 -> lineB[47:40]=8'h41; lineA unchanged.
- 0xA7 then data 0x58, 0x59 -> nothing stored (0x27 off-screen; 0x58 then 0x59 goes to lineB char 0 -> lineB[7:0]=8'h59); addr=0x41.
- Strobe 0x01, then a second strobe 10 cycles later -> second strobe ignored; proto_err=1. A status read during busy returns DB_out[7]=1.
- Assert rst mid-EXEC after 0x01 -> the next cycle has busy=0, FSM=IDLE, and all outputs at reset values.
